// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every handshake and bus signal around the memory port arbiter.
//   clk and resetn are not part of the bundle; they stay plain ports.
//
//   Signal groups:
//     inst_*  fetch requester: req/addr in, addr_ok/data_ok/rdata out
//     data_*  load/store requester: req/wr/size/wstrb/addr/wdata in,
//             addr_ok/data_ok/rdata out
//     mem_*   shared sram-like port: req and latched request fields out,
//             addr_ok/data_ok/rdata in
//     busy    arbiter has a transaction in flight
//
//   Modports:
//     slave   the arbiter itself (serves both requesters, drives memory)
//     master  the environment: requesters plus the memory model
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output busy
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one sram-like memory port between instruction fetch and the data
//   requester. One transaction is outstanding at a time: it is accepted in
//   IDLE, presented to memory in REQ, waits for the response in WAIT and is
//   returned to its originator in RESP. The data side wins ties unless fetch
//   has been passed over STARVE_MAX times in a row.
//
//   Ports:
//     clk     rising-edge clock
//     resetn  synchronous active-low reset
//     bus     mem_port_arbiter_if.slave (requesters, memory port, busy)
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    state_t            state_next;

    // Low in the reset cycle and the first cycle after it, so no grant (and
    // hence no output activity) happens until the arbiter has settled.
    logic              ready;
    logic              owner;        // 0 = inst, 1 = data
    logic [3:0]        starve_cnt;
    logic              grant_inst;
    logic              grant_data;

    logic              wr_q;
    logic [1:0]        size_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] resp_q;

    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
    endfunction

    always_comb begin
        state_next = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                if (ready) begin
                    // Fetch is forced only once it has been starved long enough.
                    if (bus.data_req && !(bus.inst_req && starve_cnt == STARVE_LIM))
                        grant_data = 1'b1;
                    else if (bus.inst_req)
                        grant_inst = 1'b1;
                    if (grant_data || grant_inst)
                        state_next = REQ;
                end
            end
            REQ:  if (bus.mem_addr_ok) state_next = WAIT;
            WAIT: if (bus.mem_data_ok) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            ready      <= 1'b0;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            wstrb_q    <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
        end else begin
            state <= state_next;
            ready <= 1'b1;
            if (grant_data) begin
                owner      <= 1'b1;
                wr_q       <= bus.data_wr;
                size_q     <= bus.data_size;
                wstrb_q    <= bus.data_wstrb;
                addr_q     <= bus.data_addr;
                wdata_q    <= bus.data_wdata;
                starve_cnt <= bus.inst_req ? starve_inc(starve_cnt) : 4'd0;
            end else if (grant_inst) begin
                owner      <= 1'b0;
                wr_q       <= 1'b0;
                size_q     <= 2'd2;
                wstrb_q    <= 4'd0;
                addr_q     <= bus.inst_addr;
                wdata_q    <= '0;
                starve_cnt <= 4'd0;
            end
            // Stores return zero so the requester never sees stale read data.
            if (state == WAIT && bus.mem_data_ok)
                resp_q <= wr_q ? '0 : bus.mem_rdata;
        end
    end

    assign bus.inst_addr_ok = grant_inst;
    assign bus.data_addr_ok = grant_data;
    assign bus.inst_data_ok = (state == RESP) && !owner;
    assign bus.data_data_ok = (state == RESP) && owner;
    assign bus.inst_rdata   = bus.inst_data_ok ? resp_q : '0;
    assign bus.data_rdata   = bus.data_data_ok ? resp_q : '0;

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_wr    = wr_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.busy = (state != IDLE);

endmodule
